adder_share_arbiter: RTL and testbench

- Shares one registered 32-bit carry-lookahead adder between N requesters.
- The adder has registered inputs and registered outputs, so its result appears LAT cycles after its operands are presented.
- This block arbitrates round-robin and issues at most one operation per cycle to the adder.
- It tracks each in-flight operation's requester ID through a tag pipeline, then signals completion to the correct requester when the result emerges.

---
 rtl/adder_share_arbiter_if.sv | 31 +++
 rtl/adder_share_arbiter.sv | 108 ++++++++++
 tb/tb_adder_share_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_arbiter_if.sv
// Requester and shared-adder bundle for adder_share_arbiter.
// slave = arbiter side, master = requester/adder side.
interface adder_share_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]    req_cin;

    logic [31:0]     add_a;
    logic [31:0]     add_b;
    logic            add_cin;
    logic [31:0]     add_sum;
    logic            add_cout;

    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_sum;
    logic            rsp_cout;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, add_sum, add_cout,
        output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, add_sum, add_cout,
        input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one registered adder among N requesters; optional ADDARB_PERF_CNT_EN grant counters.
// Latency: grant in cycle t -> rsp_valid in t+LAT; one op per cycle, no bubbles.
// Backpressure: none on responses; req_ready is a combinational one-hot grant, held low during reset.
module adder_share_arbiter #(
    parameter int N   = 4,
    parameter int LAT = 2,
    parameter int IDW = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    adder_share_arbiter_if.slave bus,
    output logic                 busy,
    output logic [N*16-1:0]      grant_cnt
);

    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
    } tag_t;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic           gnt_any;
    tag_t           tag_q [LAT];

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        logic [31:0] idx;
        idx     = '0;
        win     = ptr;
        gnt_any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = 32'((int'(ptr) + k) % N);
            if (!gnt_any && bus.req_valid[idx[IDW-1:0]]) begin
                gnt_any = 1'b1;
                win     = idx[IDW-1:0];
            end
        end
        if (reset) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.add_a     = '0;
        bus.add_b     = '0;
        bus.add_cin   = 1'b0;
        if (gnt_any) begin
            bus.req_ready = N'(1) << win;
            bus.add_a     = bus.req_a[int'(win)*32 +: 32];
            bus.add_b     = bus.req_b[int'(win)*32 +: 32];
            bus.add_cin   = bus.req_cin[win];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= IDW'(N-1);
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            if (gnt_any) begin
                ptr <= win;
            end
            tag_q[0] <= '{v: gnt_any, id: win};
            for (int k = 1; k < LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // The last tag stage lines up with the adder's registered output.
    always_comb begin
        bus.rsp_valid = tag_q[LAT-1].v ? (N'(1) << tag_q[LAT-1].id) : '0;
        bus.rsp_sum   = bus.add_sum;
        bus.rsp_cout  = bus.add_cout;
        busy          = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            busy = busy | tag_q[k].v;
        end
    end

`ifdef ADDARB_PERF_CNT_EN
    logic [15:0] cnt_q [N];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (gnt_any && cnt_q[win] != 16'hFFFF) begin
            cnt_q[win] <= cnt_q[win] + 16'd1;
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N; i++) begin
            grant_cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a 2-stage registered adder model.
module tb_adder_share_arbiter;

    localparam int N = 4;

    logic        clk;
    logic        reset;
    logic        busy;
    logic [63:0] grant_cnt;

    int nvec;
    int nerr;

    adder_share_arbiter_if #(.N(N)) bus ();

    adder_share_arbiter #(.N(N), .LAT(2), .IDW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared adder: registered operands, registered sum/cout.
    logic [31:0] ad_a_q, ad_b_q;
    logic        ad_cin_q;
    always @(posedge clk) begin
        if (reset) begin
            ad_a_q       <= '0;
            ad_b_q       <= '0;
            ad_cin_q     <= 1'b0;
            bus.add_sum  <= '0;
            bus.add_cout <= 1'b0;
        end else begin
            ad_a_q <= bus.add_a;
            ad_b_q <= bus.add_b;
            ad_cin_q <= bus.add_cin;
            {bus.add_cout, bus.add_sum} <= {1'b0, ad_a_q} + {1'b0, ad_b_q} + {32'b0, ad_cin_q};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic cin);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
        bus.req_cin[i]        = cin;
    endtask

    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {32'b0, cin};
    endfunction

    function automatic logic [31:0] fa(input int i, input int r);
        return 32'h1000_0000 * 32'(i + 1) + 32'(r);
    endfunction

    function automatic logic [31:0] fb(input int i);
        return 32'hC000_0000 + 32'(i);
    endfunction

    function automatic logic [63:0] rsp_word();
        return {31'b0, bus.rsp_cout, bus.rsp_sum};
    endfunction

    int          rnd [N];
    logic [32:0] exp_s [10];
    int          w;

    initial begin
        nvec = 0;
        nerr = 0;
        reset = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_cin = '0;
        @(negedge clk);
        check("ready_in_reset", 64'(bus.req_ready), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = '0;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(bus.req_ready), 64'h0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_grant_cnt", grant_cnt, 64'h0);
        check("rst_rsp_sum", rsp_word(), 64'h0);
        check("idle_add_a", 64'(bus.add_a), 64'h0);

        // Single request from req0: 5 + 3
        next_cycle();
        set_op(0, 32'h5, 32'h3, 1'b0);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        check("single_ready", 64'(bus.req_ready), 64'h1);
        check("single_add_a", 64'(bus.add_a), 64'h5);
        check("single_add_b", 64'(bus.add_b), 64'h3);
        check("single_busy_t", 64'(busy), 64'h0);
        next_cycle();
        bus.req_valid = '0;
        @(negedge clk);
        check("single_busy_t1", 64'(busy), 64'h1);
        check("single_rsp_t1", 64'(bus.rsp_valid), 64'h0);
        check("nogrant_add_a", 64'(bus.add_a), 64'h0);
        next_cycle();
        @(negedge clk);
        check("single_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        check("single_sum", rsp_word(), 64'h8);
        check("single_busy_t2", 64'(busy), 64'h1);
        next_cycle();
        @(negedge clk);
        check("single_busy_t3", 64'(busy), 64'h0);
        check("single_rsp_t3", 64'(bus.rsp_valid), 64'h0);

        // Carry propagation on req2
        next_cycle();
        set_op(2, 32'hFFFF_FFFF, 32'h0, 1'b1);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        check("carry_ready", 64'(bus.req_ready), 64'h4);
        check("carry_add_cin", 64'(bus.add_cin), 64'h1);
        next_cycle();
        bus.req_valid = '0;
        next_cycle();
        @(negedge clk);
        check("carry_rsp_valid", 64'(bus.rsp_valid), 64'h4);
        check("carry_sum", rsp_word(), 64'h1_0000_0000);

        // Move the pointer to 3 so the fairness run starts at requester 0
        next_cycle();
        set_op(3, 32'h7, 32'h8, 1'b1);
        bus.req_valid = 4'b1000;
        @(negedge clk);
        check("pre_ready", 64'(bus.req_ready), 64'h8);
        next_cycle();
        bus.req_valid = '0;
        next_cycle();
        @(negedge clk);
        check("pre_rsp", 64'(bus.rsp_valid), 64'h8);
        check("pre_sum", rsp_word(), 64'h10);

        // Fairness: all four valid for 8 cycles
        for (int i = 0; i < N; i++) rnd[i] = 0;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            if (c < 8) begin
                for (int i = 0; i < N; i++) set_op(i, fa(i, rnd[i]), fb(i), 1'(i & 1));
                bus.req_valid = 4'b1111;
                w = c % N;
                exp_s[c] = ref_add(fa(w, rnd[w]), fb(w), 1'(w & 1));
                rnd[w]++;
            end else begin
                bus.req_valid = '0;
            end
            @(negedge clk);
            if (c < 8) check($sformatf("fair_ready_%0d", c), 64'(bus.req_ready), 64'(4'b0001 << (c % N)));
            if (c >= 2) begin
                check($sformatf("fair_rsp_%0d", c), 64'(bus.rsp_valid), 64'(4'b0001 << ((c - 2) % N)));
                check($sformatf("fair_sum_%0d", c), rsp_word(), 64'(exp_s[c-2]));
            end
        end

        // Pointer resume: req1, then req0+req3 -> req3 first
        next_cycle();
        set_op(1, 32'h100, 32'h1, 1'b0);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        check("resume_req1", 64'(bus.req_ready), 64'h2);
        next_cycle();
        set_op(0, 32'h200, 32'h2, 1'b0);
        set_op(3, 32'h300, 32'h3, 1'b1);
        bus.req_valid = 4'b1001;
        @(negedge clk);
        check("resume_req3_first", 64'(bus.req_ready), 64'h8);
        next_cycle();
        bus.req_valid = 4'b0001;
        @(negedge clk);
        check("resume_req0_next", 64'(bus.req_ready), 64'h1);
        check("resume_rsp1", 64'(bus.rsp_valid), 64'h2);
        check("resume_sum1", rsp_word(), 64'h101);
        next_cycle();
        bus.req_valid = '0;
        @(negedge clk);
        check("resume_rsp3", 64'(bus.rsp_valid), 64'h8);
        check("resume_sum3", rsp_word(), 64'h304);
        next_cycle();
        @(negedge clk);
        check("resume_rsp0", 64'(bus.rsp_valid), 64'h1);
        check("resume_sum0", rsp_word(), 64'h202);

        // Reset while operations are in flight
        next_cycle();
        set_op(0, 32'h11, 32'h11, 1'b0);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        check("rmid_grant_t", 64'(bus.req_ready), 64'h1);
        next_cycle();
        reset = 1'b1;
        set_op(1, 32'h33, 32'h33, 1'b0);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        check("rmid_ready_in_reset", 64'(bus.req_ready), 64'h0);
        next_cycle();
        reset = 1'b0;
        set_op(0, 32'h20, 32'h22, 1'b0);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        check("rmid_rsp_t2", 64'(bus.rsp_valid), 64'h0);
        check("rmid_busy_t2", 64'(busy), 64'h0);
        check("rmid_new_grant", 64'(bus.req_ready), 64'h1);
        next_cycle();
        bus.req_valid = '0;
        @(negedge clk);
        check("rmid_rsp_t3", 64'(bus.rsp_valid), 64'h0);
        check("rmid_busy_t3", 64'(busy), 64'h1);
        next_cycle();
        @(negedge clk);
        check("rmid_new_rsp", 64'(bus.rsp_valid), 64'h1);
        check("rmid_new_sum", rsp_word(), 64'h42);

`ifdef ADDARB_PERF_CNT_EN
        check("cnt_after_reset", grant_cnt, 64'h1);
        next_cycle();
        set_op(0, 32'h1, 32'h1, 1'b0);
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 70000; c++) next_cycle();
        bus.req_valid = '0;
        next_cycle();
        @(negedge clk);
        check("cnt_saturate", grant_cnt, 64'h0000_0000_0000_FFFF);
`else
        check("cnt_tied_zero", grant_cnt, 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
